opb_master: RTL and testbench

OPB_MASTER -- requirements
Module: opb_master

---
 rtl/opb_master.sv | 131 +++++++++++++
 tb/tb_opb_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/opb_master.sv
// OPB bus master: turns one upstream command into a single-cycle OPB strobe,
// waits the region-dependent read latency and returns one response upstream.
module opb_master #(
  parameter logic [31:0] SLOW_BASE = 32'h0000_0800,
  parameter logic [31:0] SLOW_SIZE = 32'h0000_0100
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_WR,
  output logic [31:0] RSP_RDATA,
  output logic        OPB_RE,
  output logic        OPB_WE,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DI,
  input  logic [31:0] OPB_DO,
  output logic [15:0] TXN_CNT
);

  typedef enum logic [2:0] {IDLE, STROBE, WAIT1, WAIT2, RESP} state_t;

  state_t      state_q, state_d;
  logic        re_q, re_d, we_q, we_d;
  logic        wr_q, wr_d, rsp_wr_q, rsp_wr_d;
  logic [31:0] addr_q, addr_d, di_q, di_d, rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;

  // 33-bit compare so a slow region ending at the top of the map cannot wrap
  logic [32:0] addr_ext, slow_lo, slow_hi;
  logic        slow;

  assign addr_ext = {1'b0, addr_q};
  assign slow_lo  = {1'b0, SLOW_BASE};
  assign slow_hi  = slow_lo + {1'b0, SLOW_SIZE};
  assign slow     = (addr_ext >= slow_lo) && (addr_ext < slow_hi);

  always_comb begin
    state_d  = state_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    wr_d     = wr_q;
    rsp_wr_d = rsp_wr_q;
    addr_d   = addr_q;
    di_d     = di_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          di_d    = CMD_WDATA;
          wr_d    = CMD_WR;
          re_d    = ~CMD_WR;
          we_d    = CMD_WR;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (wr_q) begin
          rsp_wr_d = 1'b1;
          rdata_d  = 32'h0;
          state_d  = RESP;
        end else begin
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (slow) begin
          state_d = WAIT2;
        end else begin
          rsp_wr_d = 1'b0;
          rdata_d  = OPB_DO;
          state_d  = RESP;
        end
      end
      WAIT2: begin
        rsp_wr_d = 1'b0;
        rdata_d  = OPB_DO;
        state_d  = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q  <= IDLE;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      wr_q     <= 1'b0;
      rsp_wr_q <= 1'b0;
      addr_q   <= 32'h0;
      di_q     <= 32'h0;
      rdata_q  <= 32'h0;
      cnt_q    <= 16'h0;
    end else begin
      state_q  <= state_d;
      re_q     <= re_d;
      we_q     <= we_d;
      wr_q     <= wr_d;
      rsp_wr_q <= rsp_wr_d;
      addr_q   <= addr_d;
      di_q     <= di_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign CMD_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_WR    = rsp_wr_q;
  assign RSP_RDATA = rdata_q;
  assign OPB_RE    = re_q;
  assign OPB_WE    = we_q;
  assign OPB_ADDR  = addr_q;
  assign OPB_DI    = di_q;
  assign TXN_CNT   = cnt_q;

endmodule

// File: tb/tb_opb_master.sv
// Directed bench for opb_master: the bench plays the upstream client and the
// OPB decoder, driving OPB_DO only in the cycle the master should sample it.
module tb_opb_master;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WR = 1'b0;
  logic [31:0] CMD_ADDR = 32'h0;
  logic [31:0] CMD_WDATA = 32'h0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic        RSP_WR;
  logic [31:0] RSP_RDATA;
  logic        OPB_RE;
  logic        OPB_WE;
  logic [31:0] OPB_ADDR;
  logic [31:0] OPB_DI;
  logic [31:0] OPB_DO = 32'h0;
  logic [15:0] TXN_CNT;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'h0;

  opb_master dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WR(RSP_WR),
    .RSP_RDATA(RSP_RDATA),
    .OPB_RE(OPB_RE), .OPB_WE(OPB_WE), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
    .OPB_DO(OPB_DO), .TXN_CNT(TXN_CNT)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge OPB_CLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    CMD_VALID = 1'b1; CMD_WR = 1'b1; CMD_ADDR = addr; CMD_WDATA = data;
    RSP_READY = 1'b1;
    tick();
    chk("wr_we", OPB_WE, 1); chk("wr_re", OPB_RE, 0);
    chk("wr_addr", OPB_ADDR, addr); chk("wr_di", OPB_DI, data);
    CMD_VALID = 1'b0;
    tick();
    chk("wr_we_drop", OPB_WE, 0); chk("wr_rsp_valid", RSP_VALID, 1);
    chk("wr_rsp_wr", RSP_WR, 1); chk("wr_rdata", RSP_RDATA, 0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("wr_cnt", TXN_CNT, exp_cnt); chk("wr_idle", CMD_READY, 1);
    chk("wr_rsp_done", RSP_VALID, 0); chk("wr_addr_hold", OPB_ADDR, addr);
  endtask

  task automatic do_read(input logic [31:0] addr, input bit slow, input logic [31:0] data);
    CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADDR = addr; OPB_DO = ~data;
    RSP_READY = 1'b1;
    tick();
    chk("rd_re", OPB_RE, 1); chk("rd_we", OPB_WE, 0); chk("rd_addr", OPB_ADDR, addr);
    CMD_VALID = 1'b0;
    tick();
    chk("rd_re_drop", OPB_RE, 0);
    OPB_DO = slow ? ~data : data;
    if (slow) begin
      tick();
      OPB_DO = data;
    end
    tick();
    OPB_DO = ~data;
    chk("rd_rsp_valid", RSP_VALID, 1); chk("rd_rdata", RSP_RDATA, data);
    chk("rd_rsp_wr", RSP_WR, 0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("rd_cnt", TXN_CNT, exp_cnt); chk("rd_idle", CMD_READY, 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_re", OPB_RE, 0); chk("rst_we", OPB_WE, 0);
    chk("rst_addr", OPB_ADDR, 0); chk("rst_di", OPB_DI, 0);
    chk("rst_rsp_valid", RSP_VALID, 0); chk("rst_rsp_wr", RSP_WR, 0);
    chk("rst_rdata", RSP_RDATA, 0); chk("rst_cnt", TXN_CNT, 0);
    OPB_RST = 1'b0;
    tick();
    chk("rst_cmd_ready", CMD_READY, 1);

    // reset while the read strobe is high: strobe must drop without a clock
    CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADDR = 32'h0000_0808; RSP_READY = 1'b1;
    tick();
    chk("abort_strobe_up", OPB_RE, 1);
    OPB_RST = 1'b1;
    #1;
    chk("abort_re_async", OPB_RE, 0); chk("abort_addr", OPB_ADDR, 0);
    CMD_VALID = 1'b0;
    tick();
    OPB_RST = 1'b0;
    tick();
    chk("abort_ready", CMD_READY, 1);

    // reset during WAIT2 of a slow read
    CMD_VALID = 1'b1; CMD_ADDR = 32'h0000_0808;
    tick();
    CMD_VALID = 1'b0;
    tick();
    tick();
    OPB_RST = 1'b1;
    #1;
    chk("w2rst_re", OPB_RE, 0); chk("w2rst_rsp_valid", RSP_VALID, 0);
    chk("w2rst_cnt", TXN_CNT, 0);
    tick();
    OPB_RST = 1'b0;
    repeat (2) tick();
    chk("w2rst_ready", CMD_READY, 1); chk("w2rst_no_rsp", RSP_VALID, 0);
    chk("w2rst_cnt_after", TXN_CNT, 0);

    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    do_read(32'h0000_0020, 1'b0, 32'h1234_5678);
    do_read(32'h0000_0804, 1'b1, 32'hCAFE_F00D);
    do_read(32'h0000_0800, 1'b1, 32'h0800_0800);
    do_read(32'h0000_08FF, 1'b1, 32'h08FF_08FF);
    do_read(32'h0000_0900, 1'b0, 32'h0900_0900);
    do_read(32'h0000_07FF, 1'b0, 32'h07FF_07FF);
    do_read(32'hFFFF_FFFC, 1'b0, 32'hA5A5_5A5A);
    do_write(32'h0000_0804, 32'h0BAD_CAFE);

    // response back-pressure with a new command held valid throughout
    CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADDR = 32'h0000_0030;
    RSP_READY = 1'b0; OPB_DO = 32'hFFFF_0000;
    tick();
    chk("bp_strobe", OPB_RE, 1);
    CMD_ADDR = 32'h0000_0034;
    tick();
    OPB_DO = 32'h3030_3030;
    tick();
    OPB_DO = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", RSP_VALID, 1); chk("bp_rdata", RSP_RDATA, 32'h3030_3030);
      chk("bp_cmd_ready", CMD_READY, 0); chk("bp_no_strobe", OPB_RE, 0);
      tick();
    end
    chk("bp_cnt_held", TXN_CNT, exp_cnt);
    RSP_READY = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_cnt", TXN_CNT, exp_cnt); chk("bp_idle", CMD_READY, 1);
    chk("bp_idle_re", OPB_RE, 0);
    tick();
    chk("bp_next_strobe", OPB_RE, 1); chk("bp_next_addr", OPB_ADDR, 32'h0000_0034);
    CMD_VALID = 1'b0;
    tick();
    chk("bp_next_re_drop", OPB_RE, 0);
    OPB_DO = 32'h3434_3434;
    tick();
    OPB_DO = 32'hFFFF_0000;
    chk("bp_next_rdata", RSP_RDATA, 32'h3434_3434);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_next_cnt", TXN_CNT, exp_cnt);
    tick();
    chk("bp_no_dup_re", OPB_RE, 0); chk("bp_no_dup_ready", CMD_READY, 1);
    chk("bp_no_dup_cnt", TXN_CNT, exp_cnt);

    // counter wrap: stand in for 65535 prior writes by preloading the counter
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    tick();
    exp_cnt = 16'hFFFF;
    chk("wrap_preload", TXN_CNT, exp_cnt);
    do_write(32'h0000_0040, 32'h5555_AAAA);
    chk("wrap_zero", TXN_CNT, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
